board_referee: RTL
==================

# board_referee

Parametrised N×N, K-in-a-row game referee. It accepts alternating X/O moves over a valid/ready handshake and keeps the board in registers. After each move it checks only the lines through the last placed cell, then reports an illegal move, a win or a draw. It sits between the player-input front end and the display/scoring logic and supersedes the fixed 3×3 combinational board checker.

## Interface
- N, 3, board side length; legal range 3..16
- K, 3, stones in a row required to win; legal range 3..N
- CW = max(1, $clog2(N)), derived, coordinate width
- MW = $clog2(N*N+1), derived, move counter width
- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- new_game  in  1  clears the board and starts a game from any state
- move_valid  in  1  move request
- move_ready  out  1  referee can accept a move
- move_row  in  CW  target row
- move_col  in  CW  target column
- board_x  out  N*N  X occupancy; bit r*N+c
- board_o  out  N*N  O occupancy; same indexing
- turn  out  1  player to move: 0 = X, 1 = O
- move_count  out  MW  number of legal moves placed
- illegal  out  1  one-cycle pulse, rejected move
- win_x  out  1  X has K in a row
- win_o  out  1  O has K in a row
- draw  out  1  board full with no win
- game_over  out  1  high in OVER state

## Operation
- States: IDLE, WAIT, CHECK, OVER.
- Reset (async, any state) enters IDLE. In reset, every output is 0: board_x, board_o, turn, move_count, illegal, win_x, win_o, draw, game_over and move_ready.
- IDLE: move_ready is 0. new_game moves the block to WAIT.
- new_game has top priority in every state. It clears both boards, turn, move_count and all result flags, and the next state is WAIT. A handshake in the same cycle is ignored.
- WAIT: move_ready is 1. A handshake occurs when move_valid and move_ready are both 1.
  - Illegal move: row ≥ N, col ≥ N, or the cell is already set in board_x|board_o. Nothing is written. illegal pulses 1 in the next cycle. The state stays WAIT and turn is unchanged.
  - Legal move: set the cell bit in board_x (turn=0) or board_o (turn=1). Increment move_count. Latch row/col. Go to CHECK.
- CHECK: move_ready is 0. Scan four directions through the latched cell for the current player: horizontal, vertical, diagonal and anti-diagonal.
  - A win is any run of ≥K consecutive same-player cells that contains the latched cell. Runs do not wrap across board edges.
  - Win: set win_x or win_o to match turn, then go to OVER. turn is not toggled.
  - Else, if move_count == N*N: set draw, then go to OVER. A win on the final move takes precedence over draw.
  - Else: toggle turn, then go to WAIT.
- OVER: game_over is 1 and move_ready is 0. Moves are ignored and no illegal pulse is generated. Boards and flags hold until new_game or reset.
- win_x, win_o and draw are mutually exclusive. At most one is ever 1.

## Timing
- Legal handshake at edge t: the board bit and move_count are visible after t. CHECK occupies cycle t+1. Results, turn and move_ready are visible after edge t+1.
- Sustained throughput is one legal move per 2 cycles. Illegal moves can be retried every cycle.
- illegal is high for exactly the one cycle after the rejecting handshake.
- Reset asserted during CHECK clears the block immediately, with no result reported. Deassertion returns to IDLE.
- All outputs are registered. There is no combinational path from move_* to any output except through state.

## Test plan
- N=3,K=3, new_game, X:(0,0) O:(1,0) X:(0,1) O:(1,1) X:(0,2) -> win_x=1 two cycles after the 5th handshake, game_over=1, move_count=5, board_x=9'b000000111, turn=0.
- N=3, X:(1,1), then O:(1,1) -> illegal pulses 1 cycle, board_o=0, turn stays 1, move_count=1; O:(3,0) -> illegal again.
- N=3, sequence X00 O01 X02 O11 X10 O12 X21 O20 X22 -> draw=1, win_x=win_o=0, move_count=9, full board.
- N=5,K=4, X:(0,4)(1,3)(2,2)(3,1) interleaved with O:(0,0)(1,0)(2,0) -> win_x after 7th move via anti-diagonal; O's 3-run gives no win.
- N=5,K=4, X:(0,3)(0,4) and (1,0)(1,1): confirm no win across the row edge; a further move in OVER is ignored.
- Assert rst_n=0 in the CHECK cycle -> all outputs 0 immediately. After release, the block is in IDLE with move_ready=0; new_game gives move_ready=1 next cycle.

Source files
------------

// File: rtl/board_referee.sv
// N x N, K-in-a-row game referee: alternating X/O moves over valid/ready,
// board held in registers, win/draw decided from the lines through the last cell.
module board_referee #(
    parameter int N = 3,
    parameter int K = 3,
    localparam int CW = ($clog2(N) > 1) ? $clog2(N) : 1,
    localparam int MW = $clog2(N*N+1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           new_game,
    input  logic           move_valid,
    output logic           move_ready,
    input  logic [CW-1:0]  move_row,
    input  logic [CW-1:0]  move_col,
    output logic [N*N-1:0] board_x,
    output logic [N*N-1:0] board_o,
    output logic           turn,
    output logic [MW-1:0]  move_count,
    output logic           illegal,
    output logic           win_x,
    output logic           win_o,
    output logic           draw,
    output logic           game_over
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2,
        OVER  = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  row_p1;
    logic [CW-1:0]  col_p1;
    logic [N*N-1:0] cell_bit;
    logic           legal;
    logic           hs;
    logic           win_now;
    logic           full;

    // Count consecutive occupied cells stepping away from (r,c) along (dr,dc),
    // stopping at the first empty cell or board edge; never more than K-1.
    function automatic int run_len(input logic [N*N-1:0] b, input int r, input int c,
                                   input int dr, input int dc);
        int             n;
        int             rr;
        int             cc;
        logic           go;
        logic [N*N-1:0] one;
        n   = 0;
        go  = 1'b1;
        one = {{(N*N-1){1'b0}}, 1'b1};
        for (int s = 1; s < K; s++) begin
            rr = r + dr * s;
            cc = c + dc * s;
            if (go && rr >= 0 && rr < N && cc >= 0 && cc < N &&
                (|(b & (one << (rr * N + cc)))))
                n++;
            else
                go = 1'b0;
        end
        return n;
    endfunction

    // Decode the requested cell and decide whether a handshake is legal.
    always_comb begin
        int idx;
        idx      = int'(move_row) * N + int'(move_col);
        cell_bit = {{(N*N-1){1'b0}}, 1'b1} << idx;
        legal    = (int'(move_row) < N) && (int'(move_col) < N) &&
                   !(|((board_x | board_o) & cell_bit));
        hs       = move_valid && (state == WAIT);
    end

    // Scan the four lines through the latched cell for the player who just moved.
    always_comb begin
        logic [N*N-1:0] pb;
        int             r;
        int             c;
        int             dr;
        int             dc;
        int             len;
        pb      = turn ? board_o : board_x;
        r       = int'(row_p1);
        c       = int'(col_p1);
        win_now = 1'b0;
        for (int d = 0; d < 4; d++) begin
            dr  = (d == 0) ? 0 : 1;
            dc  = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
            len = 1 + run_len(pb, r, c, dr, dc) + run_len(pb, r, c, -dr, -dc);
            if (len >= K)
                win_now = 1'b1;
        end
        full = (int'(move_count) == N * N);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; new_game overrides everything else.
    always_comb begin
        state_nxt = state;
        if (new_game) begin
            state_nxt = WAIT;
        end else begin
            unique case (state)
                IDLE:    state_nxt = IDLE;
                WAIT:    if (hs && legal) state_nxt = CHECK;
                CHECK:   state_nxt = (win_now || full) ? OVER : WAIT;
                OVER:    state_nxt = OVER;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State-decoded outputs.
    always_comb begin
        move_ready = (state == WAIT);
        game_over  = (state == OVER);
    end

    // Board, turn, counter, latched cell and result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            board_x    <= '0;
            board_o    <= '0;
            turn       <= 1'b0;
            move_count <= '0;
            illegal    <= 1'b0;
            win_x      <= 1'b0;
            win_o      <= 1'b0;
            draw       <= 1'b0;
            row_p1     <= '0;
            col_p1     <= '0;
        end else begin
            illegal <= 1'b0;
            if (new_game) begin
                board_x    <= '0;
                board_o    <= '0;
                turn       <= 1'b0;
                move_count <= '0;
                win_x      <= 1'b0;
                win_o      <= 1'b0;
                draw       <= 1'b0;
            end else if (hs) begin
                if (legal) begin
                    if (turn)
                        board_o <= board_o | cell_bit;
                    else
                        board_x <= board_x | cell_bit;
                    move_count <= move_count + 1'b1;
                    row_p1     <= move_row;
                    col_p1     <= move_col;
                end else begin
                    illegal <= 1'b1;
                end
            end else if (state == CHECK) begin
                if (win_now) begin
                    if (turn)
                        win_o <= 1'b1;
                    else
                        win_x <= 1'b1;
                end else if (full) begin
                    draw <= 1'b1;
                end else begin
                    turn <= ~turn;
                end
            end
        end
    end

endmodule
